// File: rtl/data_ram_byte_lanes.sv
// Byte-lane data memory for the MIPS MEM stage: word/half/byte stores,
// extended sub-word loads, post-reset clear sequencer and sticky misalign fault.

module data_ram_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wd,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rd
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wd;

  assign rd = mem[raddr];
endmodule

module data_ram_byte_lanes #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       d,
  input  logic [1:0]        mode,
  input  logic              sign_ext,
  input  logic              we,
  input  logic              sel,
  output logic [31:0]       q,
  output logic              busy,
  output logic              misalign,
  output logic              fault
);
  localparam logic [0:0] S_CLEAR   = 1'b0;
  localparam logic [0:0] S_IDLE    = 1'b1;
  localparam logic [0:0] RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] widx;
  logic              mis_raw, store, clr_we;
  logic [3:0]        be;
  logic [3:0][7:0]   wdata, rword;
  logic [15:0]       hsel;
  logic [7:0]        bsel;
  logic [31:0]       q_raw;

  assign busy = (state == S_CLEAR);
  assign widx = addr[ADDR_W+1:2];

  always_comb begin
    mis_raw = 1'b0;
    case (mode)
      2'b01:   mis_raw = addr[0];
      2'b10:   mis_raw = 1'b0;
      default: mis_raw = |addr[1:0];
    endcase
  end

  assign misalign = sel & ~busy & mis_raw;
  // rst gates both write sources so a write in flight at reset is dropped
  assign store    = ~rst & ~busy & we & sel & ~mis_raw;
  assign clr_we   = ~rst & busy;

  always_comb begin
    be    = 4'b1111;
    wdata = d;
    case (mode)
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {d[15:0], d[15:0]};
      end
      2'b10: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{d[7:0]}};
      end
      default: ;
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lane
      data_ram_lane #(.ADDR_W(ADDR_W)) u_lane (
        .clk   (clk),
        .we    (clr_we | (store & be[i])),
        .waddr (busy ? clr_ptr : widx),
        .wd    (busy ? 8'h00 : wdata[i]),
        .raddr (widx),
        .rd    (rword[i])
      );
    end
  endgenerate

  assign hsel = addr[1] ? rword[3:2] : rword[1:0];
  assign bsel = rword[addr[1:0]];

  always_comb begin
    q_raw = rword;
    case (mode)
      2'b01:   q_raw = {{16{sign_ext & hsel[15]}}, hsel};
      2'b10:   q_raw = {{24{sign_ext & bsel[7]}}, bsel};
      default: ;
    endcase
  end

  assign q = (busy | misalign) ? 32'h0 : q_raw;

  // Clear ends on the all-ones compare so the pointer never needs to wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      clr_ptr <= '0;
      fault   <= 1'b0;
    end else if (busy) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (&clr_ptr) state <= S_IDLE;
    end else if (we & sel & mis_raw) begin
      fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_ram_byte_lanes.sv
// Self-checking bench for data_ram_byte_lanes (ADDR_W=4): clear sequencing,
// byte-lane stores, extended loads, misalignment and reset-during-clear.

module tb_data_ram_byte_lanes;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addr;
  logic [31:0] d;
  logic [1:0]  mode;
  logic        sign_ext, we, sel;
  logic [31:0] q;
  logic        busy, misalign, fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] d;
    logic [1:0]  mode;
    logic        sx, we, sel;
    logic [31:0] eq;
    logic        em, ef;
    string       nm;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] q;
    logic        mis;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  data_ram_byte_lanes #(.ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .d(d), .mode(mode), .sign_ext(sign_ext),
    .we(we), .sel(sel), .q(q), .busy(busy), .misalign(misalign), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [5:0] a, input logic [31:0] dd, input logic [1:0] m,
                              input logic sx, input logic w, input logic s,
                              input logic [31:0] eq, input logic em, input logic ef,
                              input string nm);
    vec_t v;
    v.addr = a; v.d = dd; v.mode = m; v.sx = sx; v.we = w; v.sel = s;
    v.eq = eq; v.em = em; v.ef = ef; v.nm = nm;
    tv.push_back(v);
  endfunction

  // Count edges until busy falls, bounded
  task automatic count_busy(input string nm);
    int cnt = 0;
    while (busy && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      addr = addr + 6'd4;
    end
    chk(nm, cnt, 16);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; addr = '0; d = 32'hFFFF_FFFF; mode = 2'b00; sign_ext = 1'b0;
    we = 1'b1; sel = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 1);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_misalign", {31'b0, misalign}, 0);
    chk("rst_q", q, 0);

    @(negedge clk) rst = 1'b0;
    count_busy("clear_len");
    @(negedge clk) we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 6'(i * 4);
      #1 chk($sformatf("clear_word%0d", i), q, 0);
    end

    //   addr   d             mode sx we sel  exp_q          mis fault
    add(6'h08, 32'h8899AABB, 2'b00, 0, 1, 1, 32'h00000000, 0, 0, "st_word08");
    add(6'h09, 32'h000000FF, 2'b10, 0, 1, 1, 32'h000000AA, 0, 0, "st_byte09");
    add(6'h08, 32'h0,        2'b00, 0, 0, 1, 32'h8899FFBB, 0, 0, "ld_word08");
    add(6'h09, 32'h0,        2'b10, 1, 0, 1, 32'hFFFFFFFF, 0, 0, "ld_byte09_sx");
    add(6'h09, 32'h0,        2'b10, 0, 0, 1, 32'h000000FF, 0, 0, "ld_byte09_zx");
    add(6'h04, 32'hDEADBEEF, 2'b00, 0, 1, 1, 32'h00000000, 0, 0, "st_word04");
    add(6'h06, 32'h00001234, 2'b01, 0, 1, 1, 32'h0000DEAD, 0, 0, "st_half06");
    add(6'h04, 32'h0,        2'b00, 0, 0, 1, 32'h1234BEEF, 0, 0, "ld_word04");
    add(6'h06, 32'h0,        2'b01, 1, 0, 1, 32'h00001234, 0, 0, "ld_half06_sx");
    add(6'h04, 32'h0,        2'b01, 1, 0, 1, 32'hFFFFBEEF, 0, 0, "ld_half04_sx");
    add(6'h0A, 32'hCAFEF00D, 2'b00, 0, 1, 1, 32'h00000000, 1, 1, "st_word0A_mis");
    add(6'h08, 32'h0,        2'b00, 0, 0, 1, 32'h8899FFBB, 0, 1, "ld_word08_kept");
    add(6'h01, 32'h0,        2'b01, 1, 0, 1, 32'h00000000, 1, 1, "ld_half01_mis");
    add(6'h0C, 32'h11111111, 2'b00, 0, 1, 0, 32'h00000000, 0, 1, "st_sel0");
    add(6'h0C, 32'h0,        2'b00, 0, 0, 1, 32'h00000000, 0, 1, "ld_word0C_sel0");
    add(6'h0F, 32'h00000080, 2'b10, 1, 1, 1, 32'h00000000, 0, 1, "st_byte0F");
    add(6'h0F, 32'h0,        2'b10, 1, 0, 1, 32'hFFFFFF80, 0, 1, "ld_byte0F_sx");
    add(6'h0C, 32'h0,        2'b00, 0, 0, 1, 32'h80000000, 0, 1, "ld_word0C");
    add(6'h0C, 32'h0,        2'b11, 0, 0, 1, 32'h80000000, 0, 1, "ld_rsvd0C");
    add(6'h0E, 32'h0,        2'b11, 0, 0, 1, 32'h00000000, 1, 1, "ld_rsvd0E_mis");

    foreach (tv[k]) begin
      @(negedge clk);
      addr = tv[k].addr; d = tv[k].d; mode = tv[k].mode;
      sign_ext = tv[k].sx; we = tv[k].we; sel = tv[k].sel;
      e.nm = tv[k].nm; e.q = tv[k].eq; e.mis = tv[k].em;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk({e.nm, "_q"}, q, e.q);
      chk({e.nm, "_mis"}, {31'b0, misalign}, {31'b0, e.mis});
      @(posedge clk); #1;
      chk({tv[k].nm, "_fault"}, {31'b0, fault}, {31'b0, tv[k].ef});
    end

    @(negedge clk);
    we = 1'b1; sel = 1'b1; mode = 2'b00; addr = 6'h08; d = 32'h5555_5555;
    rst = 1'b1;
    #1;
    chk("rst2_busy", {31'b0, busy}, 1);
    chk("rst2_fault", {31'b0, fault}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("mid_clear_busy", {31'b0, busy}, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    count_busy("reclear_len");
    @(negedge clk) we = 1'b0; addr = 6'h08;
    #1 chk("reclear_word08", q, 0);
    addr = 6'h04;
    #1 chk("reclear_word04", q, 0);
    chk("reclear_fault", {31'b0, fault}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_ram_byte_lanes.md
# data_ram_byte_lanes

Parametrised byte-addressable data memory for the pipelined MIPS CPU memory stage. It generalises the per-half-word RAM slice into a single block with 4 byte lanes, word/half/byte stores, and sign- or zero-extended sub-word loads. It also has a post-reset clear sequencer and a sticky misalignment fault. Reads stay combinational so MEM-stage timing is unchanged.

## Interface
- ADDR_W, 10, word-address width; depth = 2^ADDR_W words of 32 bits
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip clearing (array contents undefined)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  ADDR_W+2  byte address; [ADDR_W+1:2] selects the word, [1:0] selects the byte
- d  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- mode  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- sign_ext  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- we  in  1  write enable
- sel  in  1  chip select; a write occurs only when we & sel
- q  out  32  load data, combinational, extended per mode/sign_ext
- busy  out  1  clear sequencer is running
- misalign  out  1  combinational: current access is misaligned
- fault  out  1  sticky: a misaligned write was attempted

## Operation
- States: CLEAR, IDLE. Asynchronous rst forces state=CLEAR if CLEAR_ON_RESET=1, otherwise IDLE. Reset also forces clr_ptr=0 and fault=0.
- CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. When clr_ptr = 2^ADDR_W-1 has been written, the next state is IDLE. CLEAR lasts exactly 2^ADDR_W cycles.
- busy = (state==CLEAR). While busy, we/sel are ignored, q=0, and misalign=0.
- Misalignment: for half, addr[0]=1; for word or reserved mode, addr[1:0]≠0; byte accesses are never misaligned. The misalign signal is valid whenever sel=1; it is 0 when sel=0.
- Store (IDLE, we&sel, not misaligned), lane byte enables:
  - byte: enables lane addr[1:0] only, and writes d[7:0] into it.
  - half: enables lanes {addr[1],1}:{addr[1],0}, and writes d[15:0] into them.
  - word: enables all 4 lanes and writes d[31:0].
  - Lanes that are not enabled keep their contents.
- Misaligned store: memory is unchanged and fault is set to 1 on that edge. fault then stays 1 until rst.
- Load:
  - word: q = mem[word].
  - half: selects the half at addr[1], then extends from bit 15.
  - byte: selects the lane at addr[1:0], then extends from bit 7.
  - Extension is by sign_ext. A misaligned load returns q=0; it does not set fault.
- Little-endian lane order: lane 0 = bits [7:0].

## Timing
- Reset values: busy=1 (CLEAR_ON_RESET=1) or 0; fault=0; misalign=0; q=0 while busy.
- Write latency: 1 edge. Memory is updated at the rising edge where we&sel is sampled in IDLE.
- Read latency: 0. q follows addr/mode/sign_ext combinationally.
- Read during write to the same word: q shows the old data until the edge, and the new data after it.
- First usable write is the edge after busy falls. A write presented in the final CLEAR cycle is dropped.
- rst asserted mid-CLEAR: the sequencer restarts at clr_ptr=0 with a full 2^ADDR_W-cycle clear.
- rst asserted mid-write: the write is dropped, and the word is cleared by the subsequent CLEAR.
- clr_ptr is ADDR_W bits wide. Termination is detected by an all-ones compare, not by wrap.

## Test plan
- ADDR_W=4: release rst, hold we=sel=1 -> busy=1 for exactly 16 cycles; all 16 words read 0; writes during busy are lost.
- Word store 0x8899AABB at 0x08, then byte store 0xFF at 0x09 -> word read = 0x8899FFBB; byte load at 0x09 with sign_ext=1 -> 0xFFFFFFFF, with sign_ext=0 -> 0x000000FF.
- Half store 0x1234 at 0x06 over 0xDEADBEEF -> word at 0x04 = 0x1234BEEF; half load at 0x06 with sign_ext=1 -> 0x00001234; half load at 0x04 with sign_ext=1 -> 0xFFFFBEEF.
- Word store at 0x0A (misaligned) -> misalign=1 that cycle, memory unchanged, fault=1 from the next edge until rst; misaligned half load at 0x01 -> q=0, fault unchanged.
- sel=0 with we=1 -> no write. Same-word write then read -> q changes only after the edge.
- Assert rst at clear cycle 7 -> busy restarts and stays high for 16 more cycles; fault=0.
